pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline boundary register, generalising the EX/MEM latch into a single
//  block usable between any two stages. It carries an opaque payload bus with a valid bit
//  and obeys the 6-bit stall vector. It adds a synchronous flush, a scratch buffer for
//  multi-cycle EX ops (mul/madd/div state) and a saturating bubble counter for performance.
// PARAMETERS
//  DATA_W     108          payload width (packed wd/wreg/wdata/whilo/hi/lo/aluop/addr/reg2 etc.)
//  NOP_VALUE  {DATA_W{0}}  payload driven on reset/flush/bubble/invalid capture
//  STALL_W    6            width of stall vector
//  STAGE_IDX  3            stall bit of upstream stage; downstream bit is STAGE_IDX+1
//  TMP_W      64           multi-cycle scratch width (hilo_tmp)
//  CNT_W      2            multi-cycle step counter width
//  PERF_W     16           bubble counter width
// PORTS
//  clk         in   1        clock, all state updates on rising edge
//  rst         in   1        synchronous reset, active-high
//  stall       in   STALL_W  stall vector, 1 = Stop
//  flush       in   1        synchronous flush, active-high
//  in_payload  in   DATA_W   payload from upstream stage
//  in_valid    in   1        upstream payload holds a real instruction
//  out_payload out  DATA_W   registered payload to downstream stage
//  out_valid   out  1        registered valid
//  tmp_i       in   TMP_W    scratch state from upstream multi-cycle unit
//  cnt_i       in   CNT_W    step count from upstream multi-cycle unit
//  tmp_o       out  TMP_W    registered scratch, fed back to the multi-cycle unit
//  cnt_o       out  CNT_W    registered step count, fed back
//  perf_clr    in   1        clear bubble counter
//  bubble_cnt  out  PERF_W   saturating count of inserted bubbles
// BEHAVIOUR
//  up = stall[STAGE_IDX], dn = stall[STAGE_IDX+1]. Elaboration error if STAGE_IDX+1 >= STALL_W.
//  One register update per cycle, first matching case wins:
//  1 RESET  rst=1: out_payload=NOP_VALUE, out_valid=0, tmp_o=0, cnt_o=0, bubble_cnt=0.
//  2 FLUSH  flush=1: out_payload=NOP_VALUE, out_valid=0, tmp_o=0, cnt_o=0. Flush overrides stalls.
//  3 BUBBLE up=1,dn=0: out_payload=NOP_VALUE, out_valid=0, tmp_o<=tmp_i, cnt_o<=cnt_i
//    (multi-cycle progress is kept across the bubble); bubble_cnt+1, saturating at all-ones.
//  4 ADVANCE up=0 (dn ignored): out_valid<=in_valid; out_payload<=in_valid ? in_payload : NOP_VALUE;
//    tmp_o=0, cnt_o=0 (the multi-cycle op has completed).
//  5 HOLD   up=1,dn=1: out_payload, out_valid unchanged; tmp_o<=tmp_i, cnt_o<=cnt_i.
//  perf_clr=1 (no rst): bubble_cnt=0 this cycle; this overrides the increment from case 3.
//  bubble_cnt is affected only by rst, perf_clr and case 3; flush does not clear it.
//  Latency is 1 cycle, input to output, on ADVANCE. There are no combinational paths from inputs to outputs.
//  Reset or flush mid multi-cycle op discards scratch; the upstream unit restarts from cnt=0.
// TESTING
//  T1 rst=1 for 2 clk with in_valid=1, payload=0xABC -> out_payload=NOP_VALUE, out_valid=0, bubble_cnt=0.
//  T2 stall=6'b000000, in_payload=0x123, in_valid=1 -> next edge out_payload=0x123, out_valid=1, cnt_o=0.
//  T3 stall=6'b001111 (STAGE_IDX=3), tmp_i=64'h1_0000_0002, cnt_i=2'b01 -> out_valid=0,
//     tmp_o=64'h1_0000_0002, cnt_o=1, bubble_cnt increments by 1 per cycle.
//  T4 stall=6'b011111 after T2 -> out_payload stays 0x123, out_valid stays 1, tmp_o tracks tmp_i.
//  T5 flush=1 with stall=6'b001111 and cnt_i=2 -> out_valid=0, tmp_o=0, cnt_o=0, bubble_cnt unchanged.
//  T6 PERF_W=2, 5 consecutive bubbles -> bubble_cnt=3 (saturated); perf_clr=1 with bubble -> bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline boundary register with valid bit,
//                stall/flush control, multi-cycle scratch feedback and a
//                saturating bubble counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W    = 108,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 3,
    parameter int                TMP_W     = 64,
    parameter int                CNT_W     = 2,
    parameter int                PERF_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [DATA_W-1:0]   in_payload,
    input  logic                in_valid,
    output logic [DATA_W-1:0]   out_payload,
    output logic                out_valid,
    input  logic [TMP_W-1:0]    tmp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [TMP_W-1:0]    tmp_o,
    output logic [CNT_W-1:0]    cnt_o,
    input  logic                perf_clr,
    output logic [PERF_W-1:0]   bubble_cnt
);

    localparam int               c_UP_IDX    = STAGE_IDX;
    localparam int               c_DN_IDX    = STAGE_IDX + 1;
    localparam logic [PERF_W-1:0] c_BCNT_MAX = {PERF_W{1'b1}};

    // The downstream stall bit must exist inside the stall vector.
    if (c_DN_IDX >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
    end

    logic               w_up;
    logic               w_dn;
    logic               w_do_flush;
    logic               w_do_bubble;
    logic               w_do_advance;
    logic               w_do_hold;

    logic [DATA_W-1:0]  r_payload;
    logic               r_valid;
    logic [TMP_W-1:0]   r_tmp;
    logic [CNT_W-1:0]   r_cnt;
    logic [PERF_W-1:0]  r_bubble_cnt;

    assign w_up = stall[c_UP_IDX];
    assign w_dn = stall[c_DN_IDX];

    // Mutually exclusive update modes; flush outranks every stall combination.
    assign w_do_flush   = flush;
    assign w_do_bubble  = !flush &&  w_up && !w_dn;
    assign w_do_advance = !flush && !w_up;
    assign w_do_hold    = !flush &&  w_up &&  w_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_payload <= NOP_VALUE;
            r_valid   <= 1'b0;
        end else if (w_do_flush || w_do_bubble) begin
            r_payload <= NOP_VALUE;
            r_valid   <= 1'b0;
        end else if (w_do_advance) begin
            r_payload <= in_valid ? in_payload : NOP_VALUE;
            r_valid   <= in_valid;
        end
    end

    // Scratch survives stalls so a multi-cycle op can resume, but is dropped
    // once the op advances or the pipe is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmp <= '0;
            r_cnt <= '0;
        end else if (w_do_flush || w_do_advance) begin
            r_tmp <= '0;
            r_cnt <= '0;
        end else if (w_do_bubble || w_do_hold) begin
            r_tmp <= tmp_i;
            r_cnt <= cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            r_bubble_cnt <= '0;
        end else if (w_do_bubble && (r_bubble_cnt != c_BCNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign out_payload = r_payload;
    assign out_valid   = r_valid;
    assign tmp_o       = r_tmp;
    assign cnt_o       = r_cnt;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Randomised scoreboard bench for pipe_stage_reg against a
//                cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int                DATA_W    = 108;
    localparam logic [DATA_W-1:0] NOP_VALUE = 108'hA5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    localparam int                STALL_W   = 6;
    localparam int                STAGE_IDX = 3;
    localparam int                TMP_W     = 64;
    localparam int                CNT_W     = 2;
    localparam int                PERF_W    = 2;
    localparam int                BMAX      = (1 << PERF_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [DATA_W-1:0]   in_payload;
    logic                in_valid;
    logic [DATA_W-1:0]   out_payload;
    logic                out_valid;
    logic [TMP_W-1:0]    tmp_i;
    logic [CNT_W-1:0]    cnt_i;
    logic [TMP_W-1:0]    tmp_o;
    logic [CNT_W-1:0]    cnt_o;
    logic                perf_clr;
    logic [PERF_W-1:0]   bubble_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .NOP_VALUE(NOP_VALUE), .STALL_W(STALL_W),
        .STAGE_IDX(STAGE_IDX), .TMP_W(TMP_W), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_payload(in_payload), .in_valid(in_valid),
        .out_payload(out_payload), .out_valid(out_valid),
        .tmp_i(tmp_i), .cnt_i(cnt_i), .tmp_o(tmp_o), .cnt_o(cnt_o),
        .perf_clr(perf_clr), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] payload;
        logic              valid;
        logic [TMP_W-1:0]  tmp;
        logic [CNT_W-1:0]  cnt;
        int                bubbles;
        string             tag;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  model;
    int    vectors     = 0;
    int    miscompares = 0;
    bit    stim_done   = 1'b0;

    // Reference: what the downstream side must see after the coming edge.
    task automatic drive(input string tag, input logic r, input logic [STALL_W-1:0] s,
                         input logic f, input logic [DATA_W-1:0] p, input logic v,
                         input logic [TMP_W-1:0] t, input logic [CNT_W-1:0] c,
                         input logic pc);
        bit up, dn;
        rst = r; stall = s; flush = f; in_payload = p; in_valid = v;
        tmp_i = t; cnt_i = c; perf_clr = pc;
        up = s[STAGE_IDX];
        dn = s[STAGE_IDX+1];
        if (r) begin
            model.payload = NOP_VALUE; model.valid = 1'b0;
            model.tmp = '0; model.cnt = '0; model.bubbles = 0;
        end else begin
            if (f) begin
                model.payload = NOP_VALUE; model.valid = 1'b0;
                model.tmp = '0; model.cnt = '0;
            end else if (up && !dn) begin
                model.payload = NOP_VALUE; model.valid = 1'b0;
                model.tmp = t; model.cnt = c;
                model.bubbles = (model.bubbles + 1 > BMAX) ? BMAX : model.bubbles + 1;
            end else if (!up) begin
                model.valid = v;
                model.payload = v ? p : NOP_VALUE;
                model.tmp = '0; model.cnt = '0;
            end else begin
                model.tmp = t; model.cnt = c;
            end
            if (pc) model.bubbles = 0;
        end
        model.tag = tag;
        exp_q.push_back(model);
    endtask

    task automatic chk(input string name, input string tag,
                       input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s/%s: got %h, expected %h", tag, name, act, req);
        end
    endtask

    // Monitor: every edge produces a new registered output to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_payload", e.tag, 128'(out_payload), 128'(e.payload));
                chk("out_valid",   e.tag, 128'(out_valid),   128'(e.valid));
                chk("tmp_o",       e.tag, 128'(tmp_o),       128'(e.tmp));
                chk("cnt_o",       e.tag, 128'(cnt_o),       128'(e.cnt));
                chk("bubble_cnt",  e.tag, 128'(bubble_cnt),  128'(e.bubbles));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0]  p;
        logic [TMP_W-1:0]   t;
        logic [STALL_W-1:0] s;
        int                 sel;
        int                 wait_cyc;
        model.payload = NOP_VALUE; model.valid = 1'b0;
        model.tmp = '0; model.cnt = '0; model.bubbles = 0; model.tag = "init";

        drive("T1", 1, 6'b000000, 0, 108'hABC, 1, 64'h5, 2'd3, 0);
        @(negedge clk) drive("T1", 1, 6'b001111, 0, 108'hABC, 1, 64'h5, 2'd3, 0);
        @(negedge clk) drive("T2", 0, 6'b000000, 0, 108'h123, 1, 64'h7, 2'd2, 0);
        @(negedge clk) drive("T4", 0, 6'b011111, 0, 108'h456, 1, 64'h11, 2'd1, 0);
        @(negedge clk) drive("T4", 0, 6'b011111, 0, 108'h789, 0, 64'h22, 2'd3, 0);
        for (int i = 0; i < 3; i++)
            @(negedge clk) drive("T3", 0, 6'b001111, 0, 108'h999, 1, 64'h1_0000_0002, 2'b01, 0);
        @(negedge clk) drive("T5", 0, 6'b001111, 1, 108'h321, 1, 64'h33, 2'd2, 0);
        @(negedge clk) drive("T6c", 0, 6'b000000, 0, 108'h0, 0, 64'h0, 2'd0, 1);
        for (int i = 0; i < 5; i++)
            @(negedge clk) drive("T6", 0, 6'b001000, 0, 108'h1, 1, 64'(i), 2'(i), 0);
        @(negedge clk) drive("T6clr", 0, 6'b001000, 0, 108'h2, 1, 64'h44, 2'd1, 1);
        @(negedge clk) drive("adv", 0, 6'b110111, 0, 108'hF00D, 1, 64'h55, 2'd2, 0);
        @(negedge clk) drive("rst_mid", 1, 6'b001000, 0, 108'h1, 1, 64'h66, 2'd3, 0);

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            p   = {$urandom, $urandom, $urandom, $urandom};
            t   = {$urandom, $urandom};
            s   = STALL_W'($urandom);
            sel = $urandom_range(0, 99);
            drive("rand", sel < 2, s, sel >= 2 && sel < 8, p, 1'($urandom),
                  t, CNT_W'($urandom), $urandom_range(0, 15) == 0);
        end

        stim_done = 1'b1;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
